// File: rtl/register_file.sv
// register_file: architectural registers x0-x31 with rename tags, operand resolution via ROB query, commit and flush.
// Optional macro REGFILE_COMMIT_BYPASS_EN: forwards a same-cycle matching commit value straight to the operands.
module register_file #(
    parameter int REG_NUM = 32,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            rename_en,
    input  logic [4:0]      rename_regid,
    input  logic [4:0]      rename_vregid,
    input  logic [4:0]      src1_regid,
    input  logic [4:0]      src2_regid,
    output logic            op1_dependency,
    output logic [4:0]      op1_vregid,
    output logic [XLEN-1:0] op1_val,
    output logic            op2_dependency,
    output logic [4:0]      op2_vregid,
    output logic [XLEN-1:0] op2_val,
    output logic [4:0]      rob_query_vregid1,
    output logic [4:0]      rob_query_vregid2,
    input  logic            rob_query_dependency1,
    input  logic [XLEN-1:0] rob_query_val1,
    input  logic            rob_query_dependency2,
    input  logic [XLEN-1:0] rob_query_val2,
    input  logic            commit_en,
    input  logic [4:0]      commit_regid,
    input  logic [4:0]      commit_dependency,
    input  logic [XLEN-1:0] commit_val
);
    logic [XLEN-1:0]    val_q [REG_NUM];
    logic [4:0]         tag_q [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic               byp1;
    logic               byp2;

    // Commit writes value and retires the rename only if its slot is the newest; rename then flush take priority on busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (commit_en && commit_regid == 5'(i)) begin
                    val_q[i] <= commit_val;
                    if (busy_q[i] && tag_q[i] == commit_dependency)
                        busy_q[i] <= 1'b0;
                end
                if (rename_en && !flush && rename_regid == 5'(i)) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= rename_vregid;
                end
                if (flush)
                    busy_q[i] <= 1'b0;
            end
        end
    end

    // Zero-latency operand resolution from pre-rename state, falling back on the ROB for busy registers
    always_comb begin
        rob_query_vregid1 = tag_q[src1_regid];
        rob_query_vregid2 = tag_q[src2_regid];
`ifdef REGFILE_COMMIT_BYPASS_EN
        byp1 = commit_en && src1_regid != 5'd0 && commit_regid == src1_regid &&
               busy_q[src1_regid] && tag_q[src1_regid] == commit_dependency;
        byp2 = commit_en && src2_regid != 5'd0 && commit_regid == src2_regid &&
               busy_q[src2_regid] && tag_q[src2_regid] == commit_dependency;
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        op1_dependency = busy_q[src1_regid] && !byp1 && rob_query_dependency1;
        op2_dependency = busy_q[src2_regid] && !byp2 && rob_query_dependency2;
        op1_vregid     = op1_dependency ? tag_q[src1_regid] : 5'd0;
        op2_vregid     = op2_dependency ? tag_q[src2_regid] : 5'd0;
        op1_val        = !busy_q[src1_regid] ? val_q[src1_regid] : byp1 ? commit_val : rob_query_val1;
        op2_val        = !busy_q[src2_regid] ? val_q[src2_regid] : byp2 ? commit_val : rob_query_val2;
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized and directed checks of register_file against an array-based reference model.
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst_n, flush, rename_en, commit_en;
    logic [4:0]  rename_regid, rename_vregid, src1_regid, src2_regid;
    logic [4:0]  commit_regid, commit_dependency;
    logic [31:0] commit_val;
    logic        op1_dependency, op2_dependency;
    logic [4:0]  op1_vregid, op2_vregid, rob_query_vregid1, rob_query_vregid2;
    logic [31:0] op1_val, op2_val;
    logic        rob_query_dependency1, rob_query_dependency2;
    logic [31:0] rob_query_val1, rob_query_val2;

    int total = 0;
    int bad = 0;

    logic [31:0] mval [32];
    logic [4:0]  mtag [32];
    logic        mbusy [32];
    logic        f1;
    logic        fd1;
    logic [31:0] fv1;

    always #5 clk = ~clk;

    register_file dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .rename_en(rename_en), .rename_regid(rename_regid), .rename_vregid(rename_vregid),
        .src1_regid(src1_regid), .src2_regid(src2_regid),
        .op1_dependency(op1_dependency), .op1_vregid(op1_vregid), .op1_val(op1_val),
        .op2_dependency(op2_dependency), .op2_vregid(op2_vregid), .op2_val(op2_val),
        .rob_query_vregid1(rob_query_vregid1), .rob_query_vregid2(rob_query_vregid2),
        .rob_query_dependency1(rob_query_dependency1), .rob_query_val1(rob_query_val1),
        .rob_query_dependency2(rob_query_dependency2), .rob_query_val2(rob_query_val2),
        .commit_en(commit_en), .commit_regid(commit_regid),
        .commit_dependency(commit_dependency), .commit_val(commit_val)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_src(input string nm, input int s, input logic rd, input logic [31:0] rv,
                             input logic dep, input logic [4:0] vr, input logic [31:0] v, input logic [4:0] q);
        check({nm, "_query"}, 32'(q), 32'(mtag[s]));
        if (!mbusy[s]) begin
            check({nm, "_dep"}, 32'(dep), 0);
            check({nm, "_vregid"}, 32'(vr), 0);
            check({nm, "_val"}, v, mval[s]);
        end else if (!rd) begin
            check({nm, "_dep"}, 32'(dep), 0);
            check({nm, "_val"}, v, rv);
        end else begin
            check({nm, "_dep"}, 32'(dep), 1);
            check({nm, "_vregid"}, 32'(vr), 32'(mtag[s]));
        end
    endtask

    // ROB stand-in: a slot committing this cycle is ready with the committed value, otherwise random
    task automatic rob_answer(input logic [4:0] q, output logic d, output logic [31:0] v);
        if (commit_en && commit_dependency == q) begin
            d = 1'b0;
            v = commit_val;
        end else begin
            d = 1'($urandom);
            v = $urandom;
        end
    endtask

    task automatic sample();
        logic d;
        logic [31:0] v;
        rob_answer(mtag[src1_regid], d, v);
        if (f1) begin
            d = fd1;
            v = fv1;
        end
        rob_query_dependency1 = d;
        rob_query_val1 = v;
        rob_answer(mtag[src2_regid], d, v);
        rob_query_dependency2 = d;
        rob_query_val2 = v;
        #1;
        if (rst_n === 1'b1 || total > 0) begin
            check_src("op1", int'(src1_regid), rob_query_dependency1, rob_query_val1,
                      op1_dependency, op1_vregid, op1_val, rob_query_vregid1);
            check_src("op2", int'(src2_regid), rob_query_dependency2, rob_query_val2,
                      op2_dependency, op2_vregid, op2_val, rob_query_vregid2);
        end
    endtask

    task automatic clock();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mval[i] = 0;
                mtag[i] = 0;
                mbusy[i] = 0;
            end
        end else begin
            if (commit_en && commit_regid != 0) begin
                mval[commit_regid] = commit_val;
                if (mbusy[commit_regid] && mtag[commit_regid] == commit_dependency)
                    mbusy[commit_regid] = 0;
            end
            if (rename_en && rename_regid != 0 && !flush) begin
                mbusy[rename_regid] = 1;
                mtag[rename_regid] = rename_vregid;
            end
            if (flush)
                for (int i = 0; i < 32; i++) mbusy[i] = 0;
        end
        @(negedge clk);
        f1 = 0;
    endtask

    task automatic idle();
        rst_n = 1; flush = 0; rename_en = 0; commit_en = 0;
        rename_regid = 0; rename_vregid = 0; commit_regid = 0; commit_dependency = 0; commit_val = 0;
    endtask

    task automatic step();
        sample();
        clock();
        idle();
    endtask

    task automatic do_rename(input logic [4:0] r, input logic [4:0] t);
        rename_en = 1; rename_regid = r; rename_vregid = t;
    endtask

    task automatic do_commit(input logic [4:0] r, input logic [4:0] t, input logic [31:0] v);
        commit_en = 1; commit_regid = r; commit_dependency = t; commit_val = v;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mval[i] = 'x;
            mtag[i] = 0;
            mbusy[i] = 0;
        end
        f1 = 0; fd1 = 0; fv1 = 0;
        idle();
        rst_n = 0; src1_regid = 0; src2_regid = 0;
        @(negedge clk);
        clock();
        idle();

        src1_regid = 5; src2_regid = 31;
        sample();
        check("reset_x5_dep", 32'(op1_dependency), 0);
        check("reset_x5_val", op1_val, 0);
        clock();

        do_rename(3, 7);
        step();
        src1_regid = 3; f1 = 1; fd1 = 1; fv1 = 0;
        sample();
        check("x3_wait_dep", 32'(op1_dependency), 1);
        check("x3_wait_vregid", 32'(op1_vregid), 7);
        check("x3_query", 32'(rob_query_vregid1), 7);
        f1 = 1; fd1 = 0; fv1 = 32'h1234;
        sample();
        check("x3_rob_val", op1_val, 32'h1234);
        clock();

        do_rename(3, 9);
        step();
        do_commit(3, 7, 32'hAA);
        step();
        src1_regid = 3; f1 = 1; fd1 = 1;
        sample();
        check("stale_busy", 32'(op1_dependency), 1);
        check("stale_tag", 32'(op1_vregid), 9);
        clock();
        do_commit(3, 9, 32'hBB);
        step();
        sample();
        check("x3_final", op1_val, 32'hBB);
        check("x3_final_dep", 32'(op1_dependency), 0);
        clock();

        do_commit(4, 2, 32'h55);
        do_rename(4, 3);
        step();
        src1_regid = 4; f1 = 1; fd1 = 1;
        sample();
        check("x4_rename_wins", 32'(op1_vregid), 3);
        clock();
        do_rename(0, 1);
        step();
        src1_regid = 0;
        sample();
        check("x0_dep", 32'(op1_dependency), 0);
        check("x0_val", op1_val, 0);
        clock();

        do_rename(1, 10);
        step();
        do_rename(2, 11);
        step();
        flush = 1;
        do_rename(6, 4);
        do_commit(1, 10, 32'h77);
        step();
        src1_regid = 1; src2_regid = 6;
        sample();
        check("flush_x1_val", op1_val, 32'h77);
        check("flush_x6_dep", 32'(op2_dependency), 0);
        clock();
        src1_regid = 2; src2_regid = 4;
        step();

        for (int n = 0; n < 2000; n++) begin
            logic [4:0] cr;
            rst_n = ($urandom_range(199) != 0);
            flush = ($urandom_range(19) == 0);
            rename_en = 1'($urandom);
            rename_regid = 5'($urandom_range(7));
            rename_vregid = 5'($urandom);
            cr = ($urandom_range(9) == 0) ? 5'($urandom) : 5'($urandom_range(7));
            commit_en = 1'($urandom);
            commit_regid = cr;
            commit_dependency = $urandom_range(1) ? mtag[cr] : 5'($urandom);
            commit_val = $urandom;
            src1_regid = ($urandom_range(9) == 0) ? 5'($urandom) : 5'($urandom_range(7));
            src2_regid = ($urandom_range(9) == 0) ? 5'($urandom) : 5'($urandom_range(7));
            step();
        end

        for (int r = 1; r < 8; r++) begin
            do_commit(5'(r), 0, 32'h100 + r);
            step();
            do_rename(5'(r), 5'(r + 16));
            step();
        end
        rst_n = 0;
        do_rename(9, 2);
        do_commit(2, 17, 32'hDEAD);
        step();
        for (int r = 0; r < 32; r += 2) begin
            src1_regid = 5'(r); src2_regid = 5'(r + 1);
            f1 = 1; fd1 = 1;
            sample();
            check("rst_op1_dep", 32'(op1_dependency), 0);
            check("rst_op1_val", op1_val, 0);
            check("rst_op2_val", op2_val, 0);
            clock();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
